// File: rtl/dmem_port.sv
// Data-memory responder: one load/store at a time over valid/ready, with byte-lane
// steering, load extension and misalignment detection around a word-organised RAM.
module dmem_port #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_mode,
    input  logic        req_byte,
    input  logic        req_signext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_done,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RESP, S_ERR} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t      state_q, state_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        signext_q, signext_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_done_q, rsp_done_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0]  req_size;
    logic        req_misaligned;
    logic        accept;
    logic [31:0] rd_word;
    logic [31:0] wr_word;
    logic [3:0]  wr_be;
    logic [31:0] load_result;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ram_we;
    logic        ram_re;

    always_comb begin
        req_size = SZ_BYTE;
        if (!req_byte) begin
            if (req_mode == 2'b10)      req_size = SZ_WORD;
            else if (req_mode == 2'b01) req_size = SZ_HALF;
        end
        req_misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                         ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        accept = req_valid && req_ready_q;
    end

    // Store lane steering: replicate the datum, then enable only the addressed lanes.
    always_comb begin
        wr_word = wdata_q;
        wr_be   = 4'b1111;
        case (size_q)
            SZ_BYTE: begin
                wr_word = {4{wdata_q[7:0]}};
                wr_be   = 4'b0001 << addr_q[1:0];
            end
            SZ_HALF: begin
                wr_word = {2{wdata_q[15:0]}};
                wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte     = 8'(rd_word >> {addr_q[1:0], 3'b000});
        ld_half     = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        load_result = rd_word;
        case (size_q)
            SZ_BYTE: load_result = {{24{signext_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: load_result = {{16{signext_q & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        signext_d   = signext_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d    = req_addr[AW+1:0];
                    size_d    = req_size;
                    signext_d = req_signext;
                    wdata_d   = req_wdata;
                    if (req_misaligned) state_d = S_ERR;
                    else if (req_write) state_d = S_WRITE;
                    else                state_d = S_READ;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ: begin
                state_d     = S_RESP;
                rsp_rdata_d = load_result;
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
        rsp_done_d  = (state_d == S_WRITE) || (state_d == S_RESP) || (state_d == S_ERR);
        rsp_err_d   = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= SZ_BYTE;
            signext_q   <= 1'b0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_done_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            signext_q   <= signext_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_done_q  <= rsp_done_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // The read is launched on the accept edge so the word is ready during READ and
    // the extended result can be registered straight into rsp_rdata for RESP.
    assign ram_re = (state_q == S_IDLE);
    assign ram_we = (state_q == S_WRITE) && !rst;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_lane_q;
            always_ff @(posedge clk) begin
                if (ram_we && wr_be[gi])
                    mem[addr_q[AW+1:2]] <= wr_word[8*gi +: 8];
                if (ram_re)
                    rd_lane_q <= mem[req_addr[AW+1:2]];
            end
            assign rd_word[8*gi +: 8] = rd_lane_q;
        end
    endgenerate

    assign req_ready = req_ready_q;
    assign rsp_done  = rsp_done_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port: stores/loads of each width, misalignment,
// handshake hold-off, address wrap and reset during a load.
module tb_dmem_port;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_mode;
    logic        req_byte;
    logic        req_signext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_done;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_rd;

    dmem_port #(.DEPTH(1024), .AW(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_mode(req_mode), .req_byte(req_byte),
        .req_signext(req_signext), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic access(input string tag, input bit w, input logic [1:0] mode,
                          input bit byt, input bit sx, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp, input bit exp_err);
        int cnt;
        int lat;
        lat = (w || exp_err) ? 1 : 2;
        check({tag, " ready_before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_mode = mode; req_byte = byt;
        req_signext = sx; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cnt = 1;
        while (!rsp_done && cnt < 8) begin
            @(negedge clk);
            cnt++;
        end
        if (!w && !exp_err) model_rd = exp;
        check({tag, " latency"}, 32'(cnt), 32'(lat));
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, " rdata"}, rsp_rdata, model_rd);
        @(negedge clk);
        $display("txn %s: addr=%h write=%0d done_after=%0d err=%0d rdata=%h",
                 tag, addr, w, cnt, rsp_err, rsp_rdata);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_mode = 2'b00;
        req_byte = 1'b0; req_signext = 1'b0; req_addr = '0; req_wdata = '0;
        model_rd = '0;
        repeat (3) @(negedge clk);
        check("reset ready", 32'(req_ready), 32'd1);
        check("reset done", 32'(rsp_done), 32'd0);
        check("reset err", 32'(rsp_err), 32'd0);
        check("reset rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        //        tag        w  mode   byt sx addr        wdata         expected      err
        access("sw_10",      1, 2'b10, 0, 0, 32'h10,     32'hDEADBEEF, 32'h0,        0);
        access("lw_10",      0, 2'b10, 0, 0, 32'h10,     32'h0,        32'hDEADBEEF, 0);
        access("sw_20",      1, 2'b10, 0, 0, 32'h20,     32'h11223344, 32'h0,        0);
        access("sb_21",      1, 2'b00, 1, 0, 32'h21,     32'h000000AA, 32'h0,        0);
        access("lw_20",      0, 2'b10, 0, 0, 32'h20,     32'h0,        32'h1122AA44, 0);
        access("lb_21",      0, 2'b00, 1, 1, 32'h21,     32'h0,        32'hFFFFFFAA, 0);
        access("lbu_21",     0, 2'b00, 1, 0, 32'h21,     32'h0,        32'h000000AA, 0);
        access("sw_30",      1, 2'b10, 0, 0, 32'h30,     32'h00000000, 32'h0,        0);
        access("sh_32",      1, 2'b01, 0, 0, 32'h32,     32'h00008001, 32'h0,        0);
        access("lw_30",      0, 2'b10, 0, 0, 32'h30,     32'h0,        32'h80010000, 0);
        access("lh_32",      0, 2'b01, 0, 1, 32'h32,     32'h0,        32'hFFFF8001, 0);
        access("lhu_32",     0, 2'b01, 0, 0, 32'h32,     32'h0,        32'h00008001, 0);
        access("lw_13_mis",  0, 2'b10, 0, 0, 32'h13,     32'h0,        32'h0,        1);
        access("sh_31_mis",  1, 2'b01, 0, 0, 32'h31,     32'h0000FFFF, 32'h0,        1);
        access("lw_30_again",0, 2'b10, 0, 0, 32'h30,     32'h0,        32'h80010000, 0);
        access("lw_1010",    0, 2'b10, 0, 0, 32'h1010,   32'h0,        32'hDEADBEEF, 0);
        access("sb_12_mode3",1, 2'b11, 0, 0, 32'h12,     32'h00000055, 32'h0,        0);
        access("lw_10_b",    0, 2'b10, 0, 0, 32'h10,     32'h0,        32'hDE55BEEF, 0);
        access("lb_13",      0, 2'b00, 1, 1, 32'h13,     32'h0,        32'hFFFFFFDE, 0);

        // req_valid held high across a whole load and into a second accept.
        req_valid = 1'b1; req_write = 1'b0; req_mode = 2'b10; req_byte = 1'b0;
        req_signext = 1'b0; req_addr = 32'h10;
        @(posedge clk); @(negedge clk);
        check("hold read ready", 32'(req_ready), 32'd0);
        check("hold read done", 32'(rsp_done), 32'd0);
        @(negedge clk);
        check("hold resp ready", 32'(req_ready), 32'd0);
        check("hold resp done", 32'(rsp_done), 32'd1);
        check("hold resp rdata", rsp_rdata, 32'hDE55BEEF);
        @(negedge clk);
        check("hold idle ready", 32'(req_ready), 32'd1);
        check("hold idle done", 32'(rsp_done), 32'd0);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check("hold second accept", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("hold second done", 32'(rsp_done), 32'd1);
        @(negedge clk);
        $display("txn hold_valid: two back-to-back loads of 0x10 rdata=%h", rsp_rdata);

        // Reset while the load sits in READ.
        req_valid = 1'b1; req_addr = 32'h20;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("rst_mid done", 32'(rsp_done), 32'd0);
        check("rst_mid ready", 32'(req_ready), 32'd1);
        check("rst_mid rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        check("rst_after done", 32'(rsp_done), 32'd0);
        check("rst_after ready", 32'(req_ready), 32'd1);
        check("rst_after rdata", rsp_rdata, 32'h0);
        $display("txn reset_mid_load: ready=%0d done=%0d rdata=%h", req_ready, rsp_done, rsp_rdata);
        model_rd = 32'h0;
        access("lw_20_post", 0, 2'b10, 0, 0, 32'h20,     32'h0,        32'h1122AA44, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
